// File: rtl/hit_pulse_generator_if.sv
// Hit-path bundle between the collision logic (master) and the pulse generator (slave).
`timescale 1ns/1ps
interface hit_pulse_generator_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CNT_W   = 4
) ();
    logic               startOfFrame;
    logic               gameActive;
    logic [NUM_SRC-1:0] collision;
    logic               monsterHit;
    logic [CNT_W-1:0]   pending;
    logic               overflow;

    modport master (
        output startOfFrame,
        output gameActive,
        output collision,
        input  monsterHit,
        input  pending,
        input  overflow
    );

    modport slave (
        input  startOfFrame,
        input  gameActive,
        input  collision,
        output monsterHit,
        output pending,
        output overflow
    );
endinterface

// File: rtl/hit_pulse_generator.sv
// Turns per-source collision levels into spaced single-cycle monsterHit pulses,
// one event per source per frame, queued in a saturating pending counter.
`timescale 1ns/1ps
module hit_pulse_generator #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input logic                  clk,
    input logic                  resetN,
    hit_pulse_generator_if.slave bus
);
    localparam int unsigned SUM_W = CNT_W + $clog2(NUM_SRC) + 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [SUM_W-1:0] MAX_CNT  = SUM_W'((2 ** CNT_W) - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e             state_q;
    logic [GAP_W-1:0]   gap_q;
    logic               hit_q;
    logic [NUM_SRC-1:0] rep_q, rep_d;
    logic [NUM_SRC-1:0] new_evt;
    logic [CNT_W-1:0]   pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic [SUM_W-1:0]   add;
    logic [SUM_W-1:0]   sum;
    logic               dec;

    always_comb begin
        new_evt = bus.collision & ({NUM_SRC{bus.startOfFrame}} | ~rep_q)
                  & {NUM_SRC{bus.gameActive}};
        // Flags keep tracking while inactive so a held hit is not recounted on re-enable.
        rep_d = bus.startOfFrame ? bus.collision : (rep_q | bus.collision);

        add = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            add = add + SUM_W'(new_evt[i]);
        end

        dec = (state_q == StIdle) && (pending_q != '0);
        sum = SUM_W'(pending_q) + add - SUM_W'(dec);

        pending_d  = sum[CNT_W-1:0];
        overflow_d = overflow_q;
        if (!bus.gameActive) begin
            pending_d = '0;
        end else if (sum > MAX_CNT) begin
            pending_d  = MAX_CNT[CNT_W-1:0];
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rep_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            rep_q      <= rep_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Emitter: hit_q is set on the same edge the FSM enters StPulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            gap_q   <= '0;
            hit_q   <= 1'b0;
        end else if (!bus.gameActive) begin
            state_q <= StIdle;
            gap_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dec) begin
                        state_q <= StPulse;
                        hit_q   <= 1'b1;
                    end
                end
                StPulse: begin
                    state_q <= StGap;
                    gap_q   <= GAP_INIT;
                    hit_q   <= 1'b0;
                end
                StGap: begin
                    if (gap_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    hit_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.monsterHit = hit_q;
    assign bus.pending    = pending_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_hit_pulse_generator.sv
// Scoreboard bench: expected pulse cycles are queued when hits are driven and popped per pulse.
`timescale 1ns/1ps
module tb_hit_pulse_generator;
    logic clk;
    logic resetN;
    logic rst2_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q1[$];
    int   exp_q2[$];

    hit_pulse_generator_if #(.NUM_SRC(4), .CNT_W(4)) bus1 ();
    hit_pulse_generator_if #(.NUM_SRC(4), .CNT_W(4)) bus2 ();

    hit_pulse_generator #(.NUM_SRC(4), .CNT_W(4), .GAP_CYCLES(2)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus1)
    );

    hit_pulse_generator #(.NUM_SRC(4), .CNT_W(4), .GAP_CYCLES(200)) dut_sat (
        .clk    (clk),
        .resetN (rst2_n),
        .bus    (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Pulse monitors: every high sample must match the next queued pulse cycle.
    always @(negedge clk) begin
        if (resetN === 1'b1 && bus1.monsterHit === 1'b1) begin
            if (exp_q1.size() == 0) check_eq("pulse_unexpected", cyc, -1);
            else check_eq("pulse_cyc", cyc, exp_q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst2_n === 1'b1 && bus2.monsterHit === 1'b1) begin
            if (exp_q2.size() == 0) check_eq("sat_pulse_unexpected", cyc, -1);
            else check_eq("sat_pulse_cyc", cyc, exp_q2.pop_front());
        end
    end

    task automatic new_frame1();
        bus1.startOfFrame = 1'b1;
        @(negedge clk);
        bus1.startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_main();
        int n;
        resetN = 1'b0;
        bus1.startOfFrame = 1'b0;
        bus1.gameActive   = 1'b1;
        bus1.collision    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_hit", bus1.monsterHit, 0);
        check_eq("rst_pending", bus1.pending, 0);
        check_eq("rst_overflow", bus1.overflow, 0);
        resetN = 1'b1;
        @(negedge clk);

        // Single source held for 500 cycles
        n = cyc;
        bus1.collision = 4'b0001;
        exp_q1.push_back(n + 2);
        @(negedge clk);
        check_eq("single_pending", bus1.pending, 1);
        wait_cyc(n + 500);
        bus1.collision = '0;
        @(negedge clk);
        check_eq("single_pending_end", bus1.pending, 0);
        check_eq("single_q_empty", exp_q1.size(), 0);
        new_frame1();

        // Three simultaneous hits
        n = cyc;
        bus1.collision = 4'b1011;
        exp_q1.push_back(n + 2);
        exp_q1.push_back(n + 6);
        exp_q1.push_back(n + 10);
        @(negedge clk);
        bus1.collision = '0;
        check_eq("simul_pending3", bus1.pending, 3);
        wait_cyc(n + 2);
        check_eq("simul_pending2", bus1.pending, 2);
        wait_cyc(n + 6);
        check_eq("simul_pending1", bus1.pending, 1);
        wait_cyc(n + 10);
        check_eq("simul_pending0", bus1.pending, 0);
        wait_cyc(n + 14);
        check_eq("simul_q_empty", exp_q1.size(), 0);
        new_frame1();

        // Level held across three frame boundaries
        n = cyc;
        bus1.collision = 4'b0100;
        exp_q1.push_back(n + 2);
        for (int f = 1; f <= 3; f++) begin
            exp_q1.push_back(n + 10 * f + 2);
            wait_cyc(n + 10 * f);
            bus1.startOfFrame = 1'b1;
            @(negedge clk);
            bus1.startOfFrame = 1'b0;
        end
        wait_cyc(n + 35);
        bus1.collision = '0;
        wait_cyc(n + 40);
        check_eq("dedupe_q_empty", exp_q1.size(), 0);
        new_frame1();

        // Flush with pending=5 during the gap
        n = cyc;
        bus1.collision = 4'b1111;
        exp_q1.push_back(n + 2);
        @(negedge clk);
        bus1.collision    = 4'b0011;
        bus1.startOfFrame = 1'b1;
        @(negedge clk);
        bus1.collision    = '0;
        bus1.startOfFrame = 1'b0;
        check_eq("flush_pending5", bus1.pending, 5);
        @(negedge clk);
        check_eq("flush_pending_gap", bus1.pending, 5);
        bus1.gameActive = 1'b0;
        @(negedge clk);
        bus1.gameActive = 1'b1;
        check_eq("flush_pending0", bus1.pending, 0);
        wait_cyc(n + 20);
        check_eq("flush_q_empty", exp_q1.size(), 0);
        check_eq("flush_overflow", bus1.overflow, 0);
        new_frame1();

        // Asynchronous reset while the pulse is high
        n = cyc;
        bus1.collision = 4'b0011;
        exp_q1.push_back(n + 2);
        @(negedge clk);
        bus1.collision = '0;
        check_eq("arst_pending_pre", bus1.pending, 2);
        @(negedge clk);
        check_eq("arst_hit_pre", bus1.monsterHit, 1);
        #1 resetN = 1'b0;
        #1;
        check_eq("arst_hit", bus1.monsterHit, 0);
        check_eq("arst_pending", bus1.pending, 0);
        check_eq("arst_overflow", bus1.overflow, 0);
        @(negedge clk);
        resetN = 1'b1;
        wait_cyc(n + 25);
        check_eq("arst_q_empty", exp_q1.size(), 0);
    endtask

    task automatic sat_frame(input int t);
        wait_cyc(t);
        bus2.startOfFrame = 1'b1;
        @(negedge clk);
        bus2.startOfFrame = 1'b0;
    endtask

    // Four sources retriggered over five frames with a 200-cycle gap: 20 events, one
    // pulse before saturation, then 15 queued pulses spaced GAP_CYCLES+2 apart.
    task automatic test_sat();
        int n0;
        rst2_n = 1'b0;
        bus2.startOfFrame = 1'b0;
        bus2.gameActive   = 1'b1;
        bus2.collision    = '0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        n0 = cyc;
        for (int j = 0; j < 16; j++) exp_q2.push_back(n0 + 2 + 202 * j);
        bus2.collision    = 4'b1111;
        bus2.startOfFrame = 1'b1;
        @(negedge clk);
        bus2.startOfFrame = 1'b0;
        sat_frame(n0 + 10);
        sat_frame(n0 + 20);
        sat_frame(n0 + 30);
        check_eq("sat_pending_max", bus2.pending, 15);
        check_eq("sat_overflow_pre", bus2.overflow, 0);
        sat_frame(n0 + 40);
        check_eq("sat_pending_clip", bus2.pending, 15);
        check_eq("sat_overflow_set", bus2.overflow, 1);
        bus2.collision = '0;
        wait_cyc(n0 + 2 + 202 * 15 + 210);
        check_eq("sat_pending_drained", bus2.pending, 0);
        check_eq("sat_overflow_sticky", bus2.overflow, 1);
        check_eq("sat_q_empty", exp_q2.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        fork
            test_main();
            test_sat();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
